// File: rtl/button_event_decoder_pkg.sv
// Shared types and default timing constants for the button gesture decoder.
// Defaults assume a 100 MHz clock.
package button_event_decoder_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOW  = 3'd0,
    ST_IDLE      = 3'd1,
    ST_PRESS1    = 3'd2,
    ST_WAIT_GAP  = 3'd3,
    ST_PRESS2    = 3'd4,
    ST_LONG_HOLD = 3'd5
  } state_e;

  localparam int unsigned LONG_CYCLES_DEFAULT = 100_000_000;
  localparam int unsigned GAP_CYCLES_DEFAULT  = 30_000_000;
  localparam int unsigned CNT_W_DEFAULT       = 27;
  localparam int unsigned EVT_CNT_W           = 8;

endpackage

// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into short, long and double press
// pulses using one FSM and one shared interval counter.
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEFAULT,
  parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DEFAULT,
  parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 level_in,
  output logic                 short_out,
  output logic                 long_out,
  output logic                 double_out,
  output logic                 held_out,
  output logic                 busy_out,
  output logic [EVT_CNT_W-1:0] evt_cnt_out
);

  // Handshake: none. level_in is sampled on every rising edge; each event
  // output is a one-cycle pulse with no back-pressure, so consumers must
  // accept it on the cycle it is high.

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 short_q, short_d;
  logic                 long_q, long_d;
  logic                 double_q, double_d;
  logic                 held_q, held_d;
  logic                 busy_q, busy_d;
  logic [EVT_CNT_W-1:0] evt_cnt_q, evt_cnt_d;

  logic long_hit;
  logic gap_hit;

  assign long_hit = (cnt_q == LONG_LAST);
  assign gap_hit  = (cnt_q == GAP_LAST);

  // State, counter and registered outputs.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q   <= ST_WAIT_LOW;
      cnt_q     <= '0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      double_q  <= 1'b0;
      held_q    <= 1'b0;
      busy_q    <= 1'b1;
      evt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      short_q   <= short_d;
      long_q    <= long_d;
      double_q  <= double_d;
      held_q    <= held_d;
      busy_q    <= busy_d;
      evt_cnt_q <= evt_cnt_d;
    end
  end

  // Next state. The counter is reloaded on every transition; the entering
  // sample of PRESS1 / WAIT_GAP already counts as sample #1.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      ST_WAIT_LOW: begin
        if (!level_in) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (level_in) begin
          state_d = ST_PRESS1;
          cnt_d   = CNT_ONE;
        end
      end
      ST_PRESS1: begin
        if (!level_in) begin
          state_d = ST_WAIT_GAP;
          cnt_d   = CNT_ONE;
        end else if (long_hit) begin
          state_d = ST_LONG_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_WAIT_GAP: begin
        if (level_in) begin
          state_d = ST_PRESS2;
        end else if (gap_hit) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_PRESS2: begin
        if (!level_in) state_d = ST_IDLE;
      end
      ST_LONG_HOLD: begin
        if (!level_in) state_d = ST_IDLE;
      end
      default: state_d = ST_WAIT_LOW;
    endcase
  end

  // Output values registered on the same edge as the transition; the three
  // pulse conditions are mutually exclusive by state and level.
  always_comb begin
    short_d   = (state_q == ST_WAIT_GAP) && !level_in && gap_hit;
    long_d    = (state_q == ST_PRESS1) && level_in && long_hit;
    double_d  = (state_q == ST_WAIT_GAP) && level_in;
    held_d    = (state_d == ST_LONG_HOLD);
    busy_d    = (state_d != ST_IDLE);
    evt_cnt_d = evt_cnt_q;
    if (short_d || long_d || double_d) begin
      evt_cnt_d = evt_cnt_q + EVT_CNT_W'(1);
    end
  end

  assign short_out   = short_q;
  assign long_out    = long_q;
  assign double_out  = double_q;
  assign held_out    = held_q;
  assign busy_out    = busy_q;
  assign evt_cnt_out = evt_cnt_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed table-driven bench for button_event_decoder with LONG_CYCLES=8,
// GAP_CYCLES=4, plus a hand-written event-counter wrap sequence.
module tb_button_event_decoder;

  localparam int unsigned LONG_C = 8;
  localparam int unsigned GAP_C  = 4;

  typedef struct {
    int       scen;
    logic     rst;
    logic     lvl;
    logic     e_short;
    logic     e_long;
    logic     e_double;
    logic     e_held;
    logic     e_busy;
    logic [7:0] e_cnt;
  } vec_t;

  logic       clk;
  logic       reset_in;
  logic       level_in;
  logic       short_out;
  logic       long_out;
  logic       double_out;
  logic       held_out;
  logic       busy_out;
  logic [7:0] evt_cnt_out;

  int   errors;
  int   checks;
  int   cur_scen;
  vec_t vecs[$];

  button_event_decoder #(
    .LONG_CYCLES(LONG_C),
    .GAP_CYCLES (GAP_C),
    .CNT_W      (4)
  ) dut (
    .clk_in     (clk),
    .reset_in   (reset_in),
    .level_in   (level_in),
    .short_out  (short_out),
    .long_out   (long_out),
    .double_out (double_out),
    .held_out   (held_out),
    .busy_out   (busy_out),
    .evt_cnt_out(evt_cnt_out)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: apply one sample and return just after the edge that took it.
  task automatic step(input logic r, input logic l);
    @(negedge clk);
    reset_in = r;
    level_in = l;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic l, input logic s, input logic lg,
                     input logic d, input logic h, input logic b, input logic [7:0] c);
    vec_t v;
    v.scen = cur_scen; v.rst = r; v.lvl = l;
    v.e_short = s; v.e_long = lg; v.e_double = d;
    v.e_held = h; v.e_busy = b; v.e_cnt = c;
    vecs.push_back(v);
  endtask

  task automatic add_n(input int n, input logic r, input logic l, input logic s,
                       input logic lg, input logic d, input logic h, input logic b,
                       input logic [7:0] c);
    for (int i = 0; i < n; i++) add(r, l, s, lg, d, h, b, c);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  initial begin
    int short_pulses;
    int other_pulses;
    logic [7:0] exp_cnt;
    errors   = 0;
    checks   = 0;
    reset_in = 1'b1;
    level_in = 1'b0;

    // 1: reset with button held, release, then a short press.
    cur_scen = 1;
    add_n(2, 1, 1, 0, 0, 0, 0, 1, 8'd0);
    add_n(18, 0, 1, 0, 0, 0, 0, 1, 8'd0);
    add(0, 0, 0, 0, 0, 0, 0, 8'd0);
    add_n(3, 0, 1, 0, 0, 0, 0, 1, 8'd0);
    add_n(3, 0, 0, 0, 0, 0, 0, 1, 8'd0);
    add(0, 0, 1, 0, 0, 0, 0, 8'd1);
    add(0, 0, 0, 0, 0, 0, 0, 8'd1);
    // 2: long press held 12 samples.
    cur_scen = 2;
    add_n(7, 0, 1, 0, 0, 0, 0, 1, 8'd1);
    add(0, 1, 0, 1, 0, 1, 1, 8'd2);
    add_n(4, 0, 1, 0, 0, 0, 1, 1, 8'd2);
    add(0, 0, 0, 0, 0, 0, 0, 8'd2);
    add(0, 0, 0, 0, 0, 0, 0, 8'd2);
    // 3: double press with a 2-sample gap.
    cur_scen = 3;
    add_n(3, 0, 1, 0, 0, 0, 0, 1, 8'd2);
    add_n(2, 0, 0, 0, 0, 0, 0, 1, 8'd2);
    add(0, 1, 0, 0, 1, 0, 1, 8'd3);
    add(0, 1, 0, 0, 0, 0, 1, 8'd3);
    add(0, 0, 0, 0, 0, 0, 0, 8'd3);
    // 4: GAP-1 lows then re-press still counts as double; PRESS2 never longs.
    cur_scen = 4;
    add(0, 1, 0, 0, 0, 0, 1, 8'd3);
    add_n(3, 0, 0, 0, 0, 0, 0, 1, 8'd3);
    add(0, 1, 0, 0, 1, 0, 1, 8'd4);
    add_n(10, 0, 1, 0, 0, 0, 0, 1, 8'd4);
    add(0, 0, 0, 0, 0, 0, 0, 8'd4);
    // 5: LONG-1 highs is short; exact GAP lows then high is a fresh press.
    cur_scen = 5;
    add_n(7, 0, 1, 0, 0, 0, 0, 1, 8'd4);
    add_n(3, 0, 0, 0, 0, 0, 0, 1, 8'd4);
    add(0, 0, 1, 0, 0, 0, 0, 8'd5);
    add_n(3, 0, 1, 0, 0, 0, 0, 1, 8'd5);
    add_n(3, 0, 0, 0, 0, 0, 0, 1, 8'd5);
    add(0, 0, 1, 0, 0, 0, 0, 8'd6);
    // 6: reset mid-PRESS1 with button still held.
    cur_scen = 6;
    add_n(5, 0, 1, 0, 0, 0, 0, 1, 8'd6);
    add(1, 1, 0, 0, 0, 0, 1, 8'd0);
    add_n(10, 0, 1, 0, 0, 0, 0, 1, 8'd0);
    add(0, 0, 0, 0, 0, 0, 0, 8'd0);
    add_n(7, 0, 1, 0, 0, 0, 0, 1, 8'd0);
    add_n(3, 0, 0, 0, 0, 0, 0, 1, 8'd0);
    add(0, 0, 1, 0, 0, 0, 0, 8'd1);
    // 7: long press then reset while held -> held cleared, busy stays.
    cur_scen = 7;
    add_n(7, 0, 1, 0, 0, 0, 0, 1, 8'd1);
    add(0, 1, 0, 1, 0, 1, 1, 8'd2);
    add(1, 1, 0, 0, 0, 0, 1, 8'd0);
    add(0, 0, 0, 0, 0, 0, 0, 8'd0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].lvl);
      checks++;
      if ({short_out, long_out, double_out, held_out, busy_out, evt_cnt_out} !==
          {vecs[i].e_short, vecs[i].e_long, vecs[i].e_double, vecs[i].e_held,
           vecs[i].e_busy, vecs[i].e_cnt}) begin
        errors++;
        $display("FAIL vec%0d scen%0d: got s=%b l=%b d=%b h=%b b=%b cnt=%0d expected s=%b l=%b d=%b h=%b b=%b cnt=%0d",
                 i, vecs[i].scen, short_out, long_out, double_out, held_out, busy_out,
                 evt_cnt_out, vecs[i].e_short, vecs[i].e_long, vecs[i].e_double,
                 vecs[i].e_held, vecs[i].e_busy, vecs[i].e_cnt);
      end
    end

    // 257 consecutive short presses: counter wraps through 0 and reads 1.
    step(1, 0);
    step(0, 0);
    short_pulses = 0;
    other_pulses = 0;
    exp_cnt      = 8'd0;
    for (int p = 0; p < 257; p++) begin
      step(0, 1);
      for (int k = 0; k < GAP_C; k++) begin
        step(0, 0);
        if (short_out) short_pulses++;
        if (long_out || double_out) other_pulses++;
      end
      exp_cnt = exp_cnt + 8'd1;
      check($sformatf("wrap_cnt_press%0d", p), {24'd0, evt_cnt_out}, {24'd0, exp_cnt});
      check($sformatf("wrap_short_press%0d", p), {31'd0, short_out}, 32'd1);
    end
    check("wrap_short_total", short_pulses, 257);
    check("wrap_other_total", other_pulses, 0);
    check("wrap_final_cnt", {24'd0, evt_cnt_out}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
